// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of the data memory: validates one request at a time,
// issues a single synchronous memory access and returns a registered completion pulse.
module lsu_mem_ctrl #(
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [4:0]       req_rd,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       mem_size,
  input  logic [31:0]      mem_rdata,
  output logic             done_valid,
  output logic             done_is_load,
  output logic [4:0]       done_rd,
  output logic [31:0]      done_data,
  output logic             err_misalign,
  output logic             err_bounds,
  output logic             err_illegal,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {StIdle, StCheck, StIssue, StCapture, StDone} state_e;

  state_e      state_q, state_d;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic [4:0]  rd_q;
  // Error vector ordering: {illegal, misalign, bounds}
  logic [2:0]  err_q, err_d;
  logic [2:0]  size_d;
  logic        illegal, misalign, oob;

  logic [31:0] mem_addr_q, mem_wdata_q, done_data_q;
  logic [2:0]  mem_size_q;
  logic        done_is_load_q;
  logic [4:0]  done_rd_q;
  logic [CNT_W-1:0] load_cnt_q, store_cnt_q, err_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    size_d  = 3'b000;
    illegal = 1'b0;
    if (is_store_q) begin
      case (funct3_q)
        3'b000:  size_d = 3'b001;
        3'b001:  size_d = 3'b010;
        3'b010:  size_d = 3'b011;
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3_q)
        3'b000:  size_d = 3'b001;
        3'b001:  size_d = 3'b010;
        3'b010:  size_d = 3'b011;
        3'b100:  size_d = 3'b101;
        3'b101:  size_d = 3'b110;
        default: illegal = 1'b1;
      endcase
    end
    // Each memory entry holds one access, so every size needs word alignment.
    misalign = (addr_q[1:0] != 2'b00);
    oob      = ({2'b00, addr_q[31:2]} >= MEM_WORDS);
    if (illegal)       err_d = 3'b100;
    else if (misalign) err_d = 3'b010;
    else if (oob)      err_d = 3'b001;
    else               err_d = 3'b000;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req_valid) state_d = StCheck;
      StCheck:   state_d = (err_d != 3'b000) ? StDone : StIssue;
      StIssue:   state_d = is_store_q ? StDone : StCapture;
      StCapture: state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      err_q      <= 3'b000;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        rd_q       <= req_rd;
      end
      if (state_q == StCheck) err_q <= err_d;
    end
  end

  // Memory-side and completion registers; loaded only on the transitions that drive them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_size_q     <= 3'b000;
      done_data_q    <= '0;
      done_is_load_q <= 1'b0;
      done_rd_q      <= '0;
      load_cnt_q     <= '0;
      store_cnt_q    <= '0;
      err_cnt_q      <= '0;
    end else begin
      unique case (state_q)
        StCheck: begin
          if (err_d == 3'b000) begin
            mem_addr_q  <= {2'b00, addr_q[31:2]};
            mem_size_q  <= size_d;
            mem_wdata_q <= wdata_q;
          end else begin
            done_data_q    <= '0;
            done_is_load_q <= ~is_store_q;
            done_rd_q      <= rd_q;
          end
        end
        StIssue: begin
          if (is_store_q) begin
            done_data_q    <= '0;
            done_is_load_q <= 1'b0;
            done_rd_q      <= rd_q;
          end
        end
        StCapture: begin
          // Memory already sign/zero extended the data.
          done_data_q    <= mem_rdata;
          done_is_load_q <= 1'b1;
          done_rd_q      <= rd_q;
        end
        StDone: begin
          if (err_q != 3'b000) err_cnt_q   <= sat_inc(err_cnt_q);
          else if (is_store_q) store_cnt_q <= sat_inc(store_cnt_q);
          else                 load_cnt_q  <= sat_inc(load_cnt_q);
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign mem_read     = (state_q == StIssue) && !is_store_q;
  assign mem_write    = (state_q == StIssue) && is_store_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_size     = mem_size_q;
  assign done_valid   = (state_q == StDone);
  assign done_is_load = done_is_load_q;
  assign done_rd      = done_rd_q;
  assign done_data    = done_data_q;
  assign err_illegal  = done_valid & err_q[2];
  assign err_misalign = done_valid & err_q[1];
  assign err_bounds   = done_valid & err_q[0];
  assign load_cnt     = load_cnt_q;
  assign store_cnt    = store_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: a negedge monitor pushes expected completions on
// acceptance and checks strobes and done pulses; scenario tasks check counters and reset.
module tb_lsu_mem_ctrl;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_addr = '0, req_wdata = '0;
  logic [4:0]    req_rd = '0;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata = '0;
  logic          mem_read, mem_write;
  logic [2:0]    mem_size;
  logic          done_valid, done_is_load;
  logic [4:0]    done_rd;
  logic [31:0]   done_data;
  logic          err_misalign, err_bounds, err_illegal;
  logic [CW-1:0] load_cnt, store_cnt, err_cnt;

  lsu_mem_ctrl #(.MEM_WORDS(64), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size), .mem_rdata(mem_rdata),
    .done_valid(done_valid), .done_is_load(done_is_load), .done_rd(done_rd),
    .done_data(done_data), .err_misalign(err_misalign), .err_bounds(err_bounds),
    .err_illegal(err_illegal), .load_cnt(load_cnt), .store_cnt(store_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    logic [2:0]  size;
    logic [2:0]  errs;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          tests_run = 0;
  int          failed = 0;
  int          cyc = 0;
  logic        strobe_seen = 1'b0;
  logic [31:0] exp_data = '0;
  logic [31:0] mem [64];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: synchronous, applies the extension encoded in the size code.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
    if (mem_read) begin
      case (mem_size)
        3'b001:  mem_rdata <= {{24{mem[mem_addr[5:0]][7]}}, mem[mem_addr[5:0]][7:0]};
        3'b010:  mem_rdata <= {{16{mem[mem_addr[5:0]][15]}}, mem[mem_addr[5:0]][15:0]};
        3'b101:  mem_rdata <= {24'h0, mem[mem_addr[5:0]][7:0]};
        3'b110:  mem_rdata <= {16'h0, mem[mem_addr[5:0]][15:0]};
        default: mem_rdata <= mem[mem_addr[5:0]];
      endcase
    end
  end

  function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [4:0] rd, input int acc);
    exp_t e;
    logic ill;
    e.st = st; e.rd = rd; e.addr = a; e.wdata = wd; e.acc = acc; e.size = 3'b000;
    ill = 1'b0;
    case (f3)
      3'b000: e.size = 3'b001;
      3'b001: e.size = 3'b010;
      3'b010: e.size = 3'b011;
      3'b100: if (st) ill = 1'b1; else e.size = 3'b101;
      3'b101: if (st) ill = 1'b1; else e.size = 3'b110;
      default: ill = 1'b1;
    endcase
    if (ill)                  e.errs = 3'b100;
    else if (a[1:0] != 2'b00) e.errs = 3'b010;
    else if (a[31:8] != 24'h0) e.errs = 3'b001;
    else                      e.errs = 3'b000;
    e.lat  = (e.errs != 3'b000) ? 2 : (st ? 3 : 4);
    e.data = (e.errs != 3'b000 || st) ? 32'h0 : exp_data;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read || mem_write) begin
        tests_run++;
        if (q.size() == 0) begin
          failed++;
          $display("FAIL strobe_unexpected: read=%0b write=%0b, required none", mem_read, mem_write);
        end else begin
          me = q[0];
          if (me.errs != 3'b000 || strobe_seen || mem_read !== !me.st || mem_write !== me.st ||
              cyc != me.acc + 2 || mem_addr !== {2'b00, me.addr[31:2]} || mem_size !== me.size ||
              (me.st && mem_wdata !== me.wdata)) begin
            failed++;
            $display("FAIL strobe: rd=%0b wr=%0b at +%0d addr=%0h size=%b wdata=%h dup=%0b; required rd=%0b wr=%0b at +2 addr=%0h size=%b wdata=%h errs=%b",
                     mem_read, mem_write, cyc - me.acc, mem_addr, mem_size, mem_wdata, strobe_seen,
                     !me.st, me.st, me.addr[31:2], me.size, me.wdata, me.errs);
          end
        end
        strobe_seen = 1'b1;
      end
      if (done_valid) begin
        tests_run++;
        if (q.size() == 0) begin
          failed++;
          $display("FAIL done_unexpected: done_valid=1, required 0");
        end else begin
          me = q.pop_front();
          if (cyc - me.acc != me.lat || done_is_load !== !me.st || done_data !== me.data ||
              (!me.st && done_rd !== me.rd) ||
              {err_illegal, err_misalign, err_bounds} !== me.errs ||
              strobe_seen !== (me.errs == 3'b000)) begin
            failed++;
            $display("FAIL done: lat=%0d is_load=%0b rd=%0d data=%h errs=%b strobe=%0b; required lat=%0d is_load=%0b rd=%0d data=%h errs=%b strobe=%0b",
                     cyc - me.acc, done_is_load, done_rd, done_data,
                     {err_illegal, err_misalign, err_bounds}, strobe_seen, me.lat, !me.st, me.rd,
                     me.data, me.errs, me.errs == 3'b000);
          end
        end
        strobe_seen = 1'b0;
      end else if ({err_illegal, err_misalign, err_bounds} !== 3'b000) begin
        tests_run++;
        failed++;
        $display("FAIL err_outside_done: errs=%b, required 000",
                 {err_illegal, err_misalign, err_bounds});
      end
      if (req_valid && req_ready)
        q.push_back(model(req_is_store, req_funct3, req_addr, req_wdata, req_rd, cyc));
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] ed);
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      tests_run++; failed++;
      $display("FAIL issue_timeout: req_ready=0, required 1");
    end
    exp_data = ed; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_rd = rd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); n++; end
    tests_run++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain_timeout: pending=%0d, required 0", q.size());
      q.delete();
    end
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; q.delete(); strobe_seen = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      failed++; $display("FAIL reset_ready: got %0b, required 1", req_ready);
    end
    tests_run++;
    if ({mem_addr, mem_wdata, mem_read, mem_write, mem_size, done_valid, done_is_load, done_rd,
         done_data, err_illegal, err_misalign, err_bounds, load_cnt, store_cnt, err_cnt} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: addr=%h wdata=%h done=%0b data=%h cnts=%0d/%0d/%0d, required all 0",
               mem_addr, mem_wdata, done_valid, done_data, load_cnt, store_cnt, err_cnt);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sw_lw();
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0);
    wait_idle();
    tests_run++;
    if (store_cnt !== 2'd1) begin
      failed++; $display("FAIL sw_store_cnt: got %0d, required 1", store_cnt);
    end
    issue(1'b0, 3'b010, 32'h10, 32'h0, 5'd7, 32'hDEADBEEF);
    wait_idle();
    tests_run++;
    if (load_cnt !== 2'd1) begin
      failed++; $display("FAIL lw_load_cnt: got %0d, required 1", load_cnt);
    end
  endtask

  task automatic test_reset_mid_load();
    issue(1'b0, 3'b010, 32'h10, 32'h0, 5'd9, 32'hDEADBEEF);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete(); strobe_seen = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      failed++; $display("FAIL midreset_ready: got %0b, required 1", req_ready);
    end
    tests_run++;
    if ({mem_addr, mem_wdata, mem_read, mem_write, mem_size, done_valid, done_is_load, done_rd,
         done_data, err_illegal, err_misalign, err_bounds} !== '0) begin
      failed++;
      $display("FAIL midreset_outputs: addr=%h wdata=%h rd=%0b done=%0b data=%h, required all 0",
               mem_addr, mem_wdata, mem_read, done_valid, done_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if ({load_cnt, store_cnt, err_cnt} !== '0) begin
      failed++;
      $display("FAIL midreset_cnts: got %0d/%0d/%0d, required 0/0/0", load_cnt, store_cnt, err_cnt);
    end
  endtask

  task automatic test_lb();
    issue(1'b1, 3'b000, 32'h20, 32'h00000080, 5'd0, 32'h0);
    issue(1'b0, 3'b000, 32'h20, 32'h0, 5'd3, 32'hFFFFFF80);
    issue(1'b0, 3'b100, 32'h20, 32'h0, 5'd4, 32'h00000080);
    wait_idle();
    tests_run++;
    if (load_cnt !== 2'd2 || store_cnt !== 2'd1) begin
      failed++;
      $display("FAIL lb_cnts: load=%0d store=%0d, required 2 and 1", load_cnt, store_cnt);
    end
  endtask

  task automatic test_errors();
    issue(1'b0, 3'b010, 32'h12, 32'h0, 5'd5, 32'h0);
    issue(1'b1, 3'b000, 32'h100, 32'h55, 5'd0, 32'h0);
    wait_idle();
    tests_run++;
    if (err_cnt !== 2'd2) begin
      failed++; $display("FAIL errors_cnt: got %0d, required 2", err_cnt);
    end
  endtask

  task automatic test_illegal();
    issue(1'b0, 3'b011, 32'h3, 32'h0, 5'd6, 32'h0);
    issue(1'b1, 3'b100, 32'h200, 32'h0, 5'd0, 32'h0);
    wait_idle();
    tests_run++;
    if (err_cnt !== 2'd3) begin
      failed++; $display("FAIL illegal_cnt: got %0d, required 3", err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int acc[5];
    int n = 0;
    int guard = 0;
    pulse_reset();
    exp_data = 32'hDEADBEEF; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    req_rd = 5'd11; req_valid = 1'b1;
    while (n < 5 && guard < 100) begin
      @(negedge clk);
      if (req_ready) begin acc[n] = cyc; n++; end
      guard++;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    tests_run++;
    if (n != 5) begin
      failed++; $display("FAIL b2b_accepts: got %0d, required 5", n);
    end
    wait_idle();
    for (int i = 1; i < 5; i++) begin
      tests_run++;
      if (acc[i] - acc[i-1] != 5) begin
        failed++; $display("FAIL b2b_spacing%0d: got %0d cycles, required 5", i, acc[i] - acc[i-1]);
      end
    end
    tests_run++;
    if (load_cnt !== 2'd3 || err_cnt !== 2'd0) begin
      failed++;
      $display("FAIL b2b_saturate: load=%0d err=%0d, required 3 and 0", load_cnt, err_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_sw_lw();
    test_reset_mid_load();
    test_lb();
    test_errors();
    test_illegal();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller sitting directly upstream of the data memory.
- Accepts one load or store request at a time from the execute stage over a valid/ready handshake.
- Checks alignment and bounds, translates funct3 into the memory's 3-bit size code, and drives the memory's synchronous read/write strobes.
- Captures the one-cycle-late read data and returns a single registered completion pulse to writeback, with error flags and saturating event counters.

Parameters:
- MEM_WORDS, 64, number of 32-bit entries in the data memory; word indices at or above this are out of bounds.
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_rd  in  5  load destination register.
- mem_addr  out  32  word index to memory.
- mem_wdata  out  32  store data to memory.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_size  out  3  memory size code.
- mem_rdata  in  32  memory read data, registered by memory.
- done_valid  out  1  one-cycle completion pulse.
- done_is_load  out  1  completed op was a load.
- done_rd  out  5  load destination register.
- done_data  out  32  load result; 0 for stores and errors.
- err_misalign  out  1  with done_valid: misaligned address.
- err_bounds  out  1  with done_valid: address out of range.
- err_illegal  out  1  with done_valid: unsupported funct3.
- load_cnt, store_cnt, err_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs and counters are 0, except req_ready=1.
  - Any in-flight operation is discarded with no done_valid.
  - A memory strobe asserted when reset hits is dropped immediately.
- Acceptance:
  - A request is accepted on the rising edge where req_valid && req_ready.
  - On acceptance the unit latches is_store, funct3, addr, wdata and rd.
  - Request inputs are ignored outside IDLE.
- Size code mapping, load (funct3 -> mem_size):
  - 000 -> 001 (LB)
  - 001 -> 010 (LH)
  - 010 -> 011 (LW)
  - 100 -> 101 (LBU)
  - 101 -> 110 (LHU)
  - Any other funct3 is illegal.
- Size code mapping, store:
  - 000 -> 001
  - 001 -> 010
  - 010 -> 011
  - Any other funct3 is illegal.
- Error checks:
  - mem_addr = latched addr >> 2.
  - Misaligned when latched addr[1:0] != 0, for all sizes, because each memory entry holds one access.
  - Out of bounds when addr[31:2] >= MEM_WORDS.
  - Priority when several apply: illegal > misalign > bounds. Exactly one error flag is set.
- State machine: IDLE -> CHECK -> ISSUE -> CAPTURE -> DONE.
  - CHECK: evaluate errors and register them. On any error go to DONE with no memory strobe. Otherwise go to ISSUE.
  - ISSUE: drive mem_addr, mem_size, mem_wdata from the latched values. Assert mem_read (load) or mem_write (store) for exactly one cycle; both strobes are never high together. Load goes to CAPTURE; store goes to DONE.
  - CAPTURE: mem_rdata is valid this cycle. Latch it into done_data; the memory already applied sign/zero extension, so pass it unmodified. Go to DONE.
  - DONE: done_valid=1 for one cycle, with done_is_load, done_rd, done_data and error flags valid. Go to IDLE.
- Strobes and memory outputs:
  - mem_read and mem_write are 0 in every state other than ISSUE.
  - mem_addr, mem_size and mem_wdata hold their last driven values outside ISSUE.
- Latency, counted from the acceptance edge:
  - Load: done_valid high in cycle +4.
  - Store: cycle +3.
  - Error: cycle +2.
  - Back-to-back: req_ready returns in the cycle after DONE.
- Counters:
  - Increment in DONE: load_cnt for a successful load, store_cnt for a successful store, err_cnt for any error.
  - Each counter saturates at all-ones and does not wrap.
- Done outputs outside DONE: done_valid and the error flags are 0; the other done_* outputs hold their values.

Test Plan:
- Reset mid-load: assert rst_n=0 in CAPTURE.
  - -> all outputs 0 and req_ready=1 asynchronously.
  - -> no done_valid afterwards.
  - -> counters 0.
- SW then LW:
  - SW addr=0x10, wdata=0xDEADBEEF -> mem_write=1, mem_addr=4, mem_size=011 for one cycle; done_valid at +3; store_cnt=1.
  - LW addr=0x10 -> mem_read at +2; done_data=0xDEADBEEF, done_rd matches, done_valid at +4.
- LB, signed and unsigned, with memory returning the extended byte 0x80:
  - funct3=000 -> mem_size=001; done_data=0xFFFFFF80.
  - funct3=100 -> mem_size=101; done_data=0x00000080.
- Errors:
  - LW addr=0x12 -> err_misalign=1.
  - SB addr=0x100 -> err_bounds=1.
  - For both: no strobe, done_valid at +2, err_cnt=2.
- Illegal with misalign: load funct3=011 at addr=0x3 -> err_illegal=1 only (priority); no strobe.
- Saturation and throughput: CNT_W=2, 5 loads back-to-back with req_valid held high -> load_cnt stays at 3; one acceptance every 5 cycles.
